if_fetch_ctrl: RTL

Instruction-fetch sequencer for the dual-issue front end. It owns the fetch PC and drives a request/acknowledge handshake to instruction memory, fetching one 64-bit pair (two instructions) per transfer. Fetched pairs go into a 2-entry buffer that decode drains. Exception and branch redirects flush the buffer and discard in-flight data; misaligned fetch addresses are reported instead of being issued.

---
 rtl/if_fetch_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - instruction-fetch sequencer with 2-entry pair buffer
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_valid,
  input  logic [31:0] exc_pc,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        id_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [63:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst0,
  output logic [31:0] if_inst1,
  output logic        if_adel
);

  typedef enum logic [1:0] {IDLE, FETCH, DROP, ERR} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] tgt, tgt_nx;
  logic [1:0]  count;
  logic        wr_ptr, rd_ptr;

  logic [31:0] q_pc   [2];
  logic [31:0] q_i0   [2];
  logic [31:0] q_i1   [2];
  logic        q_adel [2];

  logic        redirect;
  logic [31:0] redir_pc;
  logic        flush, push, pop;
  logic [31:0] push_i0, push_i1;
  logic        push_adel;
  logic        not_full;

  assign redirect  = exc_valid || br_valid;
  assign redir_pc  = exc_valid ? exc_pc : br_target;
  assign not_full  = (count != 2'd2);
  assign pop       = (count != 2'd0) && !id_stall;
  assign imem_addr = pc;

  // Head of the buffer is shown only while an entry is present; zeros otherwise.
  always_comb begin
    if_valid = (count != 2'd0);
    if_pc    = if_valid ? q_pc[rd_ptr]   : 32'd0;
    if_inst0 = if_valid ? q_i0[rd_ptr]   : 32'd0;
    if_inst1 = if_valid ? q_i1[rd_ptr]   : 32'd0;
    if_adel  = if_valid ? q_adel[rd_ptr] : 1'b0;
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state, request and buffer-control decode.
  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    tgt_nx    = tgt;
    flush     = 1'b0;
    push      = 1'b0;
    push_i0   = 32'd0;
    push_i1   = 32'd0;
    push_adel = 1'b0;
    imem_req  = 1'b0;
    case (state)
      IDLE: state_nx = FETCH;
      FETCH: begin
        imem_req = not_full && (pc[1:0] == 2'b00);
        if (redirect) begin
          flush = 1'b1;
          // An un-acked request must run to completion, so park the target.
          if (imem_req && !imem_ack) begin
            tgt_nx   = redir_pc;
            state_nx = DROP;
          end else begin
            pc_nx = redir_pc;
          end
        end else if (imem_req && imem_ack) begin
          push    = 1'b1;
          push_i0 = imem_rdata[31:0];
          push_i1 = imem_rdata[63:32];
          pc_nx   = pc + 32'd8;
        end else if (pc[1:0] != 2'b00 && not_full) begin
          push      = 1'b1;
          push_adel = 1'b1;
          state_nx  = ERR;
        end
      end
      DROP: begin
        imem_req = 1'b1;
        if (redirect) begin
          flush  = 1'b1;
          tgt_nx = redir_pc;
        end
        if (imem_ack) begin
          pc_nx    = redirect ? redir_pc : tgt;
          state_nx = FETCH;
        end
      end
      ERR: begin
        if (redirect) begin
          flush    = 1'b1;
          pc_nx    = redir_pc;
          state_nx = FETCH;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // PC, parked target and buffer occupancy; flush beats any push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= RESET_PC;
      tgt    <= RESET_PC;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      pc  <= pc_nx;
      tgt <= tgt_nx;
      if (flush) begin
        count  <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        if (push && !pop)      count <= count + 2'd1;
        else if (!push && pop) count <= count - 2'd1;
      end
    end
  end

  // Buffer storage; contents are masked by count so no reset is needed.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      q_pc[wr_ptr]   <= pc;
      q_i0[wr_ptr]   <= push_i0;
      q_i1[wr_ptr]   <= push_i1;
      q_adel[wr_ptr] <= push_adel;
    end
  end

endmodule
